// File: rtl/cnt_share_sched_if.sv
// Requester-side bus of the shared-counter scheduler: request/length inputs
// and grant/counter/status outputs, with requester (master) and scheduler (slave) views.
interface cnt_share_sched_if #(
    parameter int NREQ = 4,
    parameter int CW   = 3
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic [IDW-1:0]     cur_id;
    logic [NREQ-1:0]    done;
    logic               abort;

    modport master (
        output req, len,
        input  gnt, cnt, busy, cur_id, done, abort
    );

    modport slave (
        input  req, len,
        output gnt, cnt, busy, cur_id, done, abort
    );
endinterface

// File: rtl/cnt_share_sched.sv
// Round-robin scheduler sharing one CW-bit up-counter between NREQ requesters.
// Optional feature: define CNT_ABORT_EN to end a run early when its requester drops req.
module cnt_share_sched #(
    parameter int NREQ = 4,
    parameter int CW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    cnt_share_sched_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   len_q, len_d;
    logic            busy_q, busy_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            abort_q, abort_d;
    logic [IDW-1:0]  ptr_q, ptr_d;

    logic            req_any_s;
    logic            abort_hit_s;
    logic [IDW-1:0]  pick_s;
    logic [IDW-1:0]  next_ptr_s;
    logic [CW-1:0]   len_pick_s;

    // First set request bit found scanning from p upward, wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(p) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && r[idx]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
        return {{(NREQ-1){1'b0}}, 1'b1} << i;
    endfunction

    assign req_any_s  = |bus.req;
    assign pick_s     = rr_pick(bus.req, ptr_q);
    assign len_pick_s = bus.len[int'(pick_s)*CW +: CW];
    assign next_ptr_s = (cur_id_q == IDW'(NREQ-1)) ? {IDW{1'b0}} : cur_id_q + IDW'(1);

`ifdef CNT_ABORT_EN
    assign abort_hit_s = ~bus.req[cur_id_q];
`else
    assign abort_hit_s = 1'b0;
`endif

    // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        busy_d   = busy_q;
        cur_id_d = cur_id_q;
        done_d   = {NREQ{1'b0}};
        abort_d  = 1'b0;
        ptr_d    = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (req_any_s) begin
                    state_d  = S_RUN;
                    gnt_d    = onehot(pick_s);
                    cur_id_d = pick_s;
                    cnt_d    = {CW{1'b0}};
                    len_d    = len_pick_s;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                // Abort exits straight to IDLE, so the next cycle can arbitrate.
                if (abort_hit_s) begin
                    state_d = S_IDLE;
                    gnt_d   = {NREQ{1'b0}};
                    abort_d = 1'b1;
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr_s;
                end else if (cnt_q == len_q) begin
                    state_d = S_DONE;
                    gnt_d   = {NREQ{1'b0}};
                    done_d  = onehot(cur_id_q);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ptr_d   = next_ptr_s;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = {NREQ{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= {NREQ{1'b0}};
            cnt_q    <= {CW{1'b0}};
            len_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
            cur_id_q <= {IDW{1'b0}};
            done_q   <= {NREQ{1'b0}};
            abort_q  <= 1'b0;
            ptr_q    <= {IDW{1'b0}};
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            busy_q   <= busy_d;
            cur_id_q <= cur_id_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            ptr_q    <= ptr_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.cnt    = cnt_q;
    assign bus.busy   = busy_q;
    assign bus.cur_id = cur_id_q;
    assign bus.done   = done_q;
    assign bus.abort  = abort_q;
endmodule

// File: tb/tb_cnt_share_sched.sv
// Scoreboard bench for cnt_share_sched: a per-cycle reference model pushes expected
// outputs as stimulus is applied; they are popped and compared after each clock edge.
module tb_cnt_share_sched;
    localparam int NREQ = 4;
    localparam int CW   = 3;
    localparam int IDW  = $clog2(NREQ);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnt_share_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();
    cnt_share_sched #(.NREQ(NREQ), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [CW-1:0]   cnt;
        logic            busy;
        logic [IDW-1:0]  cur;
        logic [NREQ-1:0] done;
        logic            abort;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    int              m_state = 0;
    int              m_ptr   = 0;
    int              m_cur   = 0;
    int              m_cnt   = 0;
    int              m_left  = 0;
    logic [NREQ-1:0] m_gnt   = '0;
    logic [NREQ-1:0] m_done  = '0;
    logic            m_busy  = 1'b0;
    logic            m_abort = 1'b0;

    int              o_gnt_cyc, o_busy_cyc, o_done_cnt, o_abort_cnt, o_max_cnt;
    int              order_q[$];
    int              gcyc_q[$];
    logic [NREQ-1:0] prev_gnt = '0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    endtask

    function automatic int len_of(input int i);
        logic [CW-1:0] v;
        v = bus.len[i*CW +: CW];
        return int'(v);
    endfunction

    // Reference model: advances one clock edge using the inputs currently driven.
    function automatic void model_edge();
        int w;
        if (rst) begin
            m_state = 0; m_ptr = 0; m_cur = 0; m_cnt = 0; m_left = 0;
            m_gnt = '0; m_done = '0; m_busy = 1'b0; m_abort = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    m_done = '0; m_abort = 1'b0;
                    if (bus.req != '0) begin
                        w = -1;
                        for (int k = 0; k < NREQ; k++)
                            if (w < 0 && bus.req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                        m_state = 1; m_gnt = '0; m_gnt[w] = 1'b1; m_cur = w;
                        m_cnt = 0; m_left = len_of(w); m_busy = 1'b1;
                    end
                end
                1: begin
                    m_abort = 1'b0;
`ifdef CNT_ABORT_EN
                    if (!bus.req[m_cur]) begin
                        m_state = 0; m_gnt = '0; m_abort = 1'b1; m_busy = 1'b0;
                        m_ptr = (m_cur + 1) % NREQ;
                    end else
`endif
                    if (m_left == 0) begin
                        m_state = 2; m_gnt = '0; m_done = '0; m_done[m_cur] = 1'b1;
                    end else begin
                        m_cnt++; m_left--;
                    end
                end
                2: begin
                    m_state = 0; m_done = '0; m_busy = 1'b0; m_ptr = (m_cur + 1) % NREQ;
                end
                default: m_state = 0;
            endcase
        end
    endfunction

    task automatic clear_obs();
        o_gnt_cyc = 0; o_busy_cyc = 0; o_done_cnt = 0; o_abort_cnt = 0; o_max_cnt = 0;
        order_q.delete(); gcyc_q.delete();
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        e.gnt = m_gnt; e.cnt = CW'(m_cnt); e.busy = m_busy; e.cur = IDW'(m_cur);
        e.done = m_done; e.abort = m_abort;
        sb_q.push_back(e);
        @(posedge clk); #1;
        cyc++;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_val("gnt", 32'(bus.gnt), 32'(e.gnt));
            check_val("cnt", 32'(bus.cnt), 32'(e.cnt));
            check_val("busy", 32'(bus.busy), 32'(e.busy));
            check_val("cur_id", 32'(bus.cur_id), 32'(e.cur));
            check_val("done", 32'(bus.done), 32'(e.done));
            check_val("abort", 32'(bus.abort), 32'(e.abort));
        end
        if (bus.gnt != '0) o_gnt_cyc++;
        if (bus.busy) o_busy_cyc++;
        if (bus.done != '0) o_done_cnt++;
        if (bus.abort) o_abort_cnt++;
        if (int'(bus.cnt) > o_max_cnt) o_max_cnt = int'(bus.cnt);
        if (bus.gnt != '0 && prev_gnt == '0) begin
            order_q.push_back(int'(bus.cur_id));
            gcyc_q.push_back(cyc);
        end
        prev_gnt = bus.gnt;
        // Requesters release req once they have seen their done pulse.
        bus.req = bus.req & ~m_done;
    endtask

    task automatic run_quiet(input string tag, input int maxc);
        int n = 0;
        do begin
            step(); n++;
        end while (!(bus.req == '0 && m_state == 0) && n < maxc);
        check_val({tag, "_bound"}, 32'(n < maxc), 32'd1);
    endtask

    task automatic run_until_cnt(input int target, input int maxc);
        int n = 0;
        do begin
            step(); n++;
        end while (!(m_state == 1 && m_cnt == target) && n < maxc);
        check_val("reach_cnt_bound", 32'(n < maxc), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; bus.req = '0; bus.len = '0;
        step(); step();
        rst = 1'b0; step();
        check_val("rst_gnt", 32'(bus.gnt), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);

        // Single run, len0=2
        clear_obs();
        bus.len = {3'd0, 3'd0, 3'd0, 3'd2}; bus.req = 4'b0001;
        run_quiet("single", 40);
        check_val("single_gnt_cyc", 32'(o_gnt_cyc), 32'd3);
        check_val("single_busy_cyc", 32'(o_busy_cyc), 32'd4);
        check_val("single_done_cnt", 32'(o_done_cnt), 32'd1);
        check_val("single_max_cnt", 32'(o_max_cnt), 32'd2);

        // Round-robin, everyone requesting with len 0
        do_reset(); clear_obs();
        bus.len = '0; bus.req = 4'b1111;
        run_quiet("rr", 60);
        check_val("rr_grants", 32'(order_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < order_q.size(); i++)
            check_val($sformatf("rr_order%0d", i), 32'(order_q[i]), 32'(i));
        for (int i = 1; i < gcyc_q.size(); i++)
            check_val($sformatf("rr_spacing%0d", i), 32'(gcyc_q[i] - gcyc_q[i-1]), 32'd3);
        check_val("rr_gnt_cyc", 32'(o_gnt_cyc), 32'd4);
        check_val("rr_done_cnt", 32'(o_done_cnt), 32'd4);

        // Pointer wrap: run requester 2 so ptr lands on 3, then 3 and 0 compete
        bus.req = 4'b0100; run_quiet("pre_wrap", 20);
        clear_obs();
        bus.req = 4'b1001;
        run_quiet("wrap", 40);
        check_val("wrap_grants", 32'(order_q.size()), 32'd2);
        if (order_q.size() == 2) begin
            check_val("wrap_first", 32'(order_q[0]), 32'd3);
            check_val("wrap_second", 32'(order_q[1]), 32'd0);
        end

        // Max length with len0 changed mid-run
        clear_obs();
        bus.len = {3'd0, 3'd0, 3'd0, 3'd7}; bus.req = 4'b0001;
        step();
        bus.len[CW-1:0] = 3'd1;
        run_quiet("maxlen", 40);
        check_val("maxlen_max_cnt", 32'(o_max_cnt), 32'd7);
        check_val("maxlen_gnt_cyc", 32'(o_gnt_cyc), 32'd8);
        check_val("maxlen_done_cnt", 32'(o_done_cnt), 32'd1);

        // Reset in the middle of a run at cnt=2
        clear_obs();
        bus.len = {3'd0, 3'd0, 3'd0, 3'd5}; bus.req = 4'b0001;
        run_until_cnt(2, 20);
        rst = 1'b1; bus.req = '0;
        step(); step();
        rst = 1'b0; step();
        check_val("midrst_cnt", 32'(bus.cnt), 32'd0);
        check_val("midrst_busy", 32'(bus.busy), 32'd0);
        check_val("midrst_done_cnt", 32'(o_done_cnt), 32'd0);

        // Drop req0 at cnt=2 during a len 5 run
        clear_obs();
        bus.len = {3'd0, 3'd0, 3'd0, 3'd5}; bus.req = 4'b0001;
        run_until_cnt(2, 20);
        bus.req = '0;
        run_quiet("drop", 30);
`ifdef CNT_ABORT_EN
        check_val("drop_abort_cnt", 32'(o_abort_cnt), 32'd1);
        check_val("drop_done_cnt", 32'(o_done_cnt), 32'd0);
        check_val("drop_max_cnt", 32'(o_max_cnt), 32'd2);
`else
        check_val("drop_abort_cnt", 32'(o_abort_cnt), 32'd0);
        check_val("drop_done_cnt", 32'(o_done_cnt), 32'd1);
        check_val("drop_max_cnt", 32'(o_max_cnt), 32'd5);
`endif
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cnt_share_sched.md
Name: cnt_share_sched

Overview:
- Round-robin scheduler that shares one CW-bit up-counter between NREQ requesters; each requester asks for a count run of programmable length.
- Arbitrates, loads the counter, sequences the run, then returns a done pulse to the winning requester.
- Sits in front of the counter datapath as its only controller; all outputs are registered.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- CW, 3, counter width; run lengths range 0..2^CW-1.
- IDW, $clog2(NREQ), width of cur_id; derived, not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level; held high until done.
- len  input  NREQ*CW  flattened run lengths; requester i uses len[i*CW +: CW].
- gnt  output  NREQ  one-hot grant; high for the whole RUN phase.
- cnt  output  CW  shared counter value.
- busy  output  1  high in RUN and DONE.
- cur_id  output  IDW  index of the current/last winner.
- done  output  NREQ  one-cycle completion pulse to the winner.
- abort  output  1  one-cycle abort pulse; tied 0 unless CNT_ABORT_EN is defined.

Behaviour:
- Reset, sampled on posedge while rst=1:
  - state=IDLE; gnt=0, cnt=0, busy=0, cur_id=0, done=0, abort=0; round-robin pointer ptr=0.
  - Reset takes priority over every other event, including a run in progress: no done pulse, everything cleared next edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req!=0, pick the first set bit searching ptr, ptr+1, ... modulo NREQ.
  - Next edge: state=RUN, gnt=onehot(w), cur_id=w, cnt=0, len_q=len[w], busy=1.
  - If req==0, stay in IDLE; all outputs hold (cnt holds its last value).
- RUN:
  - Each edge, cnt=cnt+1 while cnt!=len_q.
  - When cnt==len_q, next edge: state=DONE, gnt=0, done[w]=1, cnt holds len_q.
  - Run occupies len_q+1 cycles (cnt values 0..len_q); len=0 gives a single RUN cycle with cnt=0.
- DONE:
  - Lasts exactly one cycle with busy=1.
  - Next edge: state=IDLE, done=0, busy=0, ptr=(w+1) mod NREQ.
- Handshake:
  - len[w] is sampled only at the grant edge; later changes are ignored.
  - Requester w should drop req on the edge after it sees done.
  - If req[w] is still high in the following IDLE, it is eligible again, but with lowest priority.
- Timing: req seen in IDLE -> gnt one cycle later. Turnaround between back-to-back runs is DONE + IDLE, i.e. 2 cycles with gnt=0.
- Wrap-around: ptr wraps NREQ-1 -> 0. cnt never exceeds len_q, so no counter overflow is possible.
- Simultaneous requests resolve only through ptr; there are no ties. Requests arriving during RUN/DONE wait for IDLE.
- Without CNT_ABORT_EN, dropping req[w] during RUN is ignored; the run completes and done pulses.

Optional Feature:
- Macro: CNT_ABORT_EN.
- Defined:
  - If req[w]=0 on any RUN-state edge, next edge: state=IDLE, gnt=0, abort=1 for one cycle, no done pulse, cnt holds, ptr=(w+1) mod NREQ, busy=0.
  - The abort cycle acts as IDLE, so arbitration may occur in it.
- Undefined: abort tied 0; behaviour exactly as in Behaviour.

Test Plan:
- Reset: rst=1 for 2 cycles mid-run (cnt=2) -> next cycle gnt=0, cnt=0, busy=0, done=0; no done pulse for the interrupted run.
- Single run: req=0001, len0=2 -> gnt=0001 for 3 cycles with cnt=0,1,2; then done=0001 for 1 cycle; busy high for 4 cycles total.
- Round-robin with all requesting: req=1111, all len=0, each requester drops req after its done -> grant order 0,1,2,3; each gnt 1 cycle, each done 1 cycle, 3 cycles per grant.
- Pointer wrap: ptr=3, req=1001 -> 3 granted first; after its done, 0 granted (ptr wrapped to 0).
- Max length and mid-run len change: len0=7 -> cnt runs 0..7 (8 RUN cycles), no overflow; changing len0 to 1 during RUN has no effect.
- Abort (CNT_ABORT_EN defined): len0=5, drop req0 when cnt=2 -> next cycle abort=1, gnt=0, no done, cnt=2. Same stimulus with the macro undefined -> run completes to cnt=5 and done0 pulses.
